// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-bit pad synchronizer, debounce filter and edge-event pulses
module gpio_in_filter #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad,
  input  logic [DEB_W-1:0] deb_cycles,
  output logic [WIDTH-1:0] gpio,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_any
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] upd;
  logic [DEB_W-1:0] cnt [WIDTH];
  assign s = sync_q[SYNC_STAGES-1];
  // a bit updates once its new level has been seen for more than deb_cycles evaluations
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) upd[i] = (s[i] != gpio[i]) && (cnt[i] >= deb_cycles);
  end
  // metastability chain, stage 0 samples the raw pads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  // counters clear on agreement or update, so a bounce restarts the count and nothing wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    else for (int i = 0; i < WIDTH; i++) cnt[i] <= (s[i] == gpio[i] || upd[i]) ? '0 : cnt[i] + DEB_W'(1);
  // stable level register and one-cycle edge pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gpio <= '0;
      rise <= '0;
      fall <= '0;
      evt_any <= 1'b0;
    end else begin
      gpio <= gpio ^ upd;
      rise <= upd & s;
      fall <= upd & ~s;
      evt_any <= |upd;
    end
endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: scoreboard bench, stimulus queues expected outputs per cycle, monitor checks them
module tb_gpio_in_filter;
  logic clk = 0;
  logic rst_n = 1;
  logic [31:0] pad = '0;
  logic [15:0] deb = '0;
  logic [31:0] gpio, rise, fall;
  logic evt_any;
  int e = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {int cyc; logic [31:0] g; logic [31:0] r; logic [31:0] f; logic v;} exp_t;
  exp_t q[$];

  gpio_in_filter #(.WIDTH(32), .SYNC_STAGES(2), .DEB_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pad(pad), .deb_cycles(deb),
    .gpio(gpio), .rise(rise), .fall(fall), .evt_any(evt_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  task automatic cmp(string name, int cyc, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h want %h", name, cyc, act, want);
    end
  endtask

  task automatic push(int d, logic [31:0] g, logic [31:0] r, logic [31:0] f, logic v);
    q.push_back('{e + d, g, r, f, v});
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_zero(string name);
    cmp({name, "_gpio"}, e, gpio, 32'h0);
    cmp({name, "_rise"}, e, rise, 32'h0);
    cmp({name, "_fall"}, e, fall, 32'h0);
    cmp({name, "_evt"}, e, {31'b0, evt_any}, 32'h0);
  endtask

  // monitor: compare whatever the DUT presents at the cycle an expectation is due
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < e) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stale expectation @edge %0d: got edge %0d want edge %0d", q[0].cyc, e, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == e) begin
      cmp("gpio", e, gpio, q[0].g);
      cmp("rise", e, rise, q[0].r);
      cmp("fall", e, fall, q[0].f);
      cmp("evt_any", e, {31'b0, evt_any}, {31'b0, q[0].v});
      void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    // 1: no filtering, 3-edge latency
    pad = 32'h1;
    push(2, 32'h0, 32'h0, 32'h0, 1'b0);
    push(3, 32'h1, 32'h1, 32'h0, 1'b1);
    push(4, 32'h1, 32'h0, 32'h0, 1'b0);
    drain();
    // 2: deb=4, 7 edges
    deb = 16'd4;
    pad = 32'h21;
    push(6, 32'h1, 32'h0, 32'h0, 1'b0);
    push(7, 32'h21, 32'h20, 32'h0, 1'b1);
    push(8, 32'h21, 32'h0, 32'h0, 1'b0);
    drain();
    // 3: 4-cycle glitch rejected
    pad = 32'hA1;
    for (int d = 5; d <= 10; d++) push(d, 32'h21, 32'h0, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    pad = 32'h21;
    drain();
    repeat (3) @(negedge clk);
    // 3b: 5-cycle pulse passes, then falls
    pad = 32'hA1;
    push(6, 32'h21, 32'h0, 32'h0, 1'b0);
    push(7, 32'hA1, 32'h80, 32'h0, 1'b1);
    push(8, 32'hA1, 32'h0, 32'h0, 1'b0);
    push(11, 32'hA1, 32'h0, 32'h0, 1'b0);
    push(12, 32'h21, 32'h0, 32'h80, 1'b1);
    push(13, 32'h21, 32'h0, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    pad = 32'h21;
    drain();
    // 4: deb=3, simultaneous multi-bit events
    deb = 16'd3;
    pad = 32'hFFFF_0000;
    push(6, 32'hFFFF_0000, 32'hFFFF_0000, 32'h21, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    pad = 32'h0000_FFFF;
    push(5, 32'hFFFF_0000, 32'h0, 32'h0, 1'b0);
    push(6, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1);
    push(7, 32'h0000_FFFF, 32'h0, 32'h0, 1'b0);
    drain();
    // 5: deb=10 lowered to 2 while cnt=6
    deb = 16'd10;
    pad = 32'h0001_FFFF;
    push(8, 32'h0000_FFFF, 32'h0, 32'h0, 1'b0);
    push(9, 32'h0001_FFFF, 32'h0001_0000, 32'h0, 1'b1);
    push(10, 32'h0001_FFFF, 32'h0, 32'h0, 1'b0);
    repeat (8) @(negedge clk);
    deb = 16'd2;
    drain();
    // 6: async reset mid-count, then all bits rise after release
    deb = 16'd3;
    pad = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_zero("async_reset");
    repeat (2) @(negedge clk);
    chk_zero("held_reset");
    rst_n = 1;
    push(5, 32'h0, 32'h0, 32'h0, 1'b0);
    push(6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    push(7, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
